alu_seq_param: RTL

ALU_SEQ_PARAM -- requirements
Module: alu_seq_param

---
 rtl/alu_seq_param.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq_param.sv
// Sequential ALU: loads two operands over a shared bus, then add/sub in one cycle,
// radix-4 Booth multiply in WIDTH/2 cycles, or restoring divide in WIDTH cycles.
//
// state  | meaning
// IDLE   | waiting for BEGIN; last ovf/dbz held
// LOAD_X | capture first operand from inbus
// LOAD_Y | capture second operand, set up the datapath
// EXEC   | iterate (1, WIDTH/2 or WIDTH cycles)
// OUT_HI | product high word / quotient on outbus
// OUT_LO | product low word / remainder / add-sub result, END pulse
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             BEGIN,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] inbus,
  output logic [WIDTH-1:0] outbus,
  output logic             out_valid,
  output logic             busy,
  output logic             ovf,
  output logic             dbz,
  output logic             END
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_X = 3'd1;
  localparam logic [2:0] LOAD_Y = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] OUT_HI = 3'd4;
  localparam logic [2:0] OUT_LO = 3'd5;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  logic [2:0]         state;
  logic [1:0]         op_reg;
  logic [WIDTH-1:0]   x_reg;
  logic [WIDTH-1:0]   y_reg;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH:0]     mq;
  logic [CW-1:0]      cnt;

  logic [CW-1:0]      tc;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic               add_ovf;
  logic               sub_ovf;
  logic [2*WIDTH-1:0] booth_add;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_sub;

  always_comb begin
    case (op_reg)
      OP_MUL:  tc = CW'(WIDTH / 2 - 1);
      OP_DIV:  tc = CW'(WIDTH - 1);
      default: tc = '0;
    endcase
  end

  assign sum     = x_reg + y_reg;
  assign diff    = x_reg - y_reg;
  assign add_ovf = (x_reg[WIDTH-1] == y_reg[WIDTH-1]) && (sum[WIDTH-1] != x_reg[WIDTH-1]);
  assign sub_ovf = (x_reg[WIDTH-1] != y_reg[WIDTH-1]) && (diff[WIDTH-1] != x_reg[WIDTH-1]);

  // mq holds the unconsumed multiplier bits with the implicit zero below bit 0;
  // mcand is the sign-extended multiplicand already aligned to the current digit.
  always_comb begin
    case (mq[2:0])
      3'b001, 3'b010: booth_add = mcand;
      3'b011:         booth_add = mcand << 1;
      3'b100:         booth_add = -(mcand << 1);
      3'b101, 3'b110: booth_add = -mcand;
      default:        booth_add = '0;
    endcase
  end

  // Divide keeps {remainder, quotient/dividend} in acc and shifts left each step.
  assign rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, y_reg};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      op_reg <= OP_ADD;
      x_reg  <= '0;
      y_reg  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mq     <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (BEGIN) begin
            op_reg <= op_code;
            ovf    <= 1'b0;
            dbz    <= 1'b0;
            state  <= LOAD_X;
          end
        end
        LOAD_X: begin
          x_reg <= inbus;
          state <= LOAD_Y;
        end
        LOAD_Y: begin
          y_reg <= inbus;
          cnt   <= '0;
          mq    <= {x_reg, 1'b0};
          mcand <= {{WIDTH{inbus[WIDTH-1]}}, inbus};
          if (op_reg == OP_DIV && inbus == '0) begin
            acc   <= {x_reg, {WIDTH{1'b1}}};
            state <= OUT_HI;
          end else begin
            acc   <= (op_reg == OP_DIV) ? {{WIDTH{1'b0}}, x_reg} : '0;
            state <= EXEC;
          end
        end
        EXEC: begin
          cnt <= cnt + CW'(1);
          case (op_reg)
            OP_ADD: begin
              acc[2*WIDTH-1:WIDTH] <= sum;
              ovf                  <= add_ovf;
            end
            OP_SUB: begin
              acc[2*WIDTH-1:WIDTH] <= diff;
              ovf                  <= sub_ovf;
            end
            OP_MUL: begin
              acc   <= acc + booth_add;
              mcand <= mcand << 2;
              mq    <= mq >> 2;
            end
            default: begin
              if (!rem_sub[WIDTH])
                acc <= {rem_sub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
              else
                acc <= {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
          endcase
          if (cnt == tc)
            state <= (op_reg == OP_MUL || op_reg == OP_DIV) ? OUT_HI : OUT_LO;
        end
        OUT_HI: begin
          dbz   <= (op_reg == OP_DIV) && (y_reg == '0);
          state <= OUT_LO;
        end
        OUT_LO: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Add/sub results and remainders live in the upper half of acc.
  always_comb begin
    outbus = '0;
    case (state)
      OUT_HI:  outbus = (op_reg == OP_MUL) ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
      OUT_LO:  outbus = (op_reg == OP_MUL) ? acc[WIDTH-1:0] : acc[2*WIDTH-1:WIDTH];
      default: outbus = '0;
    endcase
  end

  assign out_valid = (state == OUT_HI) || (state == OUT_LO);
  assign END       = (state == OUT_LO);
  assign busy      = (state != IDLE);

endmodule
